// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment display path:
// digit count, blank pattern, hex-to-segment table and anode one-hot helper.
package seg_pkg;

    localparam int         DIGITS    = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX7_TABLE [0:15] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic logic [6:0] hex7(input logic [3:0] value);
        return HEX7_TABLE[value];
    endfunction

    // Active-low one-hot anode select for digit idx
    function automatic logic [DIGITS-1:0] anode_onehot_n(input logic [1:0] idx);
        return ~(DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for a slow asynchronous
// level. After reset the detector only arms once the synchronised input has
// been seen low, so a level that is already high at reset release is not
// mistaken for a fresh rising edge.
module tick_sync_edge (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_dly;
    logic r_fill1;
    logic r_fill2;
    logic r_armed;

    // Synchroniser chain and the delay flop used for edge detection
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    // Arm only after r_sync2 holds a real sample of the input and it is low
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_fill1 <= 1'b0;
            r_fill2 <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_fill1 <= 1'b1;
            r_fill2 <= r_fill1;
            if (r_fill2 && !r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign rise_pulse = r_sync2 & ~r_dly & r_armed;

endmodule

// File: rtl/lfsr_seg_display.sv
// Display stage for the LFSR generator: captures the LFSR state on each
// divided-clock tick into a four-deep history and scans it onto a 4-digit
// common-anode seven-segment display, newest value on digit 0.
module lfsr_seg_display
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 2**17
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        tick_in,
    input  logic [3:0]  state_in,
    input  logic        hold,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic [7:0]  sample_cnt
);

    localparam int                RCNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);

    logic              w_cap;
    logic              w_accept;
    logic              w_rcnt_tc;

    logic [3:0]        r_hist [DIGITS];
    logic [DIGITS-1:0] r_vld;
    logic [7:0]        r_sample_cnt;
    logic [RCNT_W-1:0] r_rcnt;
    logic [1:0]        r_idx;
    logic [6:0]        r_seg_n;
    logic              r_dp_n;
    logic [3:0]        r_an_n;

    tick_sync_edge u_tick_sync (
        .clk_in     (clk_in),
        .reset      (reset),
        .async_in   (tick_in),
        .rise_pulse (w_cap)
    );

    assign w_accept  = w_cap & ~hold;
    assign w_rcnt_tc = (r_rcnt == RCNT_LAST);

    // History and valid shift register plus accepted-capture counter
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_hist       <= '{default: '0};
            r_vld        <= '0;
            r_sample_cnt <= '0;
        end else if (w_accept) begin
            for (int i = DIGITS - 1; i > 0; i--) begin
                r_hist[i] <= r_hist[i-1];
            end
            r_hist[0]    <= state_in;
            r_vld        <= {r_vld[DIGITS-2:0], 1'b1};
            r_sample_cnt <= r_sample_cnt + 8'd1;
        end
    end

    // Refresh divider; each terminal count steps to the next digit slot
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_rcnt <= '0;
            r_idx  <= '0;
        end else if (w_rcnt_tc) begin
            r_rcnt <= '0;
            r_idx  <= r_idx + 2'd1;
        end else begin
            r_rcnt <= r_rcnt + RCNT_W'(1);
        end
    end

    // Anode and segments registered together so they switch on the same edge
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_an_n  <= '1;
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
        end else begin
            r_an_n  <= anode_onehot_n(r_idx);
            r_seg_n <= r_vld[r_idx] ? hex7(r_hist[r_idx]) : SEG_BLANK;
            r_dp_n  <= ~((r_idx == 2'd0) & r_vld[0]);
        end
    end

    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign an_n       = r_an_n;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_lfsr_seg_display.sv
// Bench for lfsr_seg_display with REFRESH_DIV=4: a cycle-level reference
// model of capture history and digit scanning, plus directed scenarios.
module tb_lfsr_seg_display;

    localparam int DIV = 4;

    logic       clk_in   = 1'b0;
    logic       reset    = 1'b1;
    logic       tick_in  = 1'b0;
    logic [3:0] state_in = 4'd0;
    logic       hold     = 1'b0;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic [7:0] sample_cnt;

    int n_vec = 0;
    int n_err = 0;

    lfsr_seg_display #(.REFRESH_DIV(DIV)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .tick_in    (tick_in),
        .state_in   (state_in),
        .hold       (hold),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .sample_cnt (sample_cnt)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [6:0] ref_hex(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Reference model: edges since reset release, newest-first history list,
    // capture count, and the edges at which detected ticks land.
    int m_edge = 0;
    int m_hist [4];
    int m_n    = 0;
    int m_cnt  = 0;
    bit m_prev = 1'b1;
    int m_pend [$];

    // Model update and per-cycle compare, sampled 1 time unit after each edge
    always @(posedge clk_in) begin : model_cmp
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         idx;
        if (reset) begin
            m_edge = 0;
            m_n    = 0;
            m_cnt  = 0;
            m_prev = 1'b1;
            m_pend.delete();
            e_an   = 4'hF;
            e_seg  = 7'h7F;
            e_dp   = 1'b1;
        end else begin
            m_edge = m_edge + 1;
            // Digit shown after this edge is the slot that was current before it
            idx   = ((m_edge - 1) / DIV) % 4;
            e_an  = ~(4'(1) << idx);
            e_seg = (idx < m_n) ? ref_hex(m_hist[idx]) : 7'h7F;
            e_dp  = !(idx == 0 && m_n > 0);
            if (m_pend.size() > 0 && m_pend[0] == m_edge) begin
                void'(m_pend.pop_front());
                if (!hold) begin
                    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
                    m_hist[0] = int'(state_in);
                    if (m_n < 4) m_n = m_n + 1;
                    m_cnt = (m_cnt + 1) % 256;
                end
            end
            // A rise seen at edge E1 becomes a capture at E1+2
            if (tick_in && !m_prev) m_pend.push_back(m_edge + 2);
            m_prev = tick_in;
        end
        #1;
        n_vec++;
        if ({an_n, seg_n, dp_n, sample_cnt} !== {e_an, e_seg, e_dp, 8'(m_cnt)}) begin
            n_err++;
            $display("FAIL model edge %0d: an/seg/dp/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                     m_edge, an_n, seg_n, dp_n, sample_cnt, e_an, e_seg, e_dp, m_cnt);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Caller must be sitting on a negedge
    task automatic tick(input logic [3:0] s, input int hi, input int lo);
        state_in = s;
        tick_in  = 1'b1;
        repeat (hi) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (lo) @(negedge clk_in);
    endtask

    task automatic check_digit(input int d, input logic [6:0] exp_seg, input logic exp_dp);
        logic [3:0] want;
        bit         found;
        want  = ~(4'(1) << d);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk_in);
            if (an_n == want) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL digit%0d_timeout: an_n got %b want %b", d, an_n, want);
        end else begin
            chk($sformatf("digit%0d_seg", d), 32'(seg_n), 32'(exp_seg));
            chk($sformatf("digit%0d_dp", d), 32'(dp_n), 32'(exp_dp));
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] c0;
        bit         aligned;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        @(posedge clk_in); #1;
        chk("release_an", 32'(an_n), 32'b1110);
        chk("release_seg", 32'(seg_n), 32'h7F);

        // Single capture of 9 and its latency
        repeat (4) @(negedge clk_in);
        state_in = 4'h9;
        tick_in  = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in); #1;
        chk("cnt_after_E2", 32'(sample_cnt), 32'd0);
        @(posedge clk_in); #1;
        chk("cnt_after_E3", 32'(sample_cnt), 32'd1);
        repeat (8) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (8) @(negedge clk_in);
        check_digit(0, 7'b0010000, 1'b0);
        check_digit(1, 7'h7F, 1'b1);
        check_digit(2, 7'h7F, 1'b1);
        check_digit(3, 7'h7F, 1'b1);

        // Reset mid-scan: outputs drop immediately
        @(negedge clk_in);
        #2 reset = 1'b1;
        #1;
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'd1);
        chk("rst_cnt", 32'(sample_cnt), 32'd0);
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (4) @(negedge clk_in);

        // History shift
        tick(4'h1, 8, 8);
        tick(4'hA, 8, 8);
        tick(4'hF, 8, 8);
        tick(4'h0, 8, 8);
        chk("shift_cnt", 32'(sample_cnt), 32'd4);
        check_digit(3, 7'b1111001, 1'b1);
        check_digit(2, 7'b0001000, 1'b1);
        check_digit(1, 7'b0001110, 1'b1);
        check_digit(0, 7'b1000000, 1'b0);

        // Hold drops ticks; release does not replay them
        hold = 1'b1;
        repeat (3) tick(4'h5, 8, 8);
        hold = 1'b0;
        chk("hold_cnt", 32'(sample_cnt), 32'd4);
        check_digit(0, 7'b1000000, 1'b0);
        @(negedge clk_in);
        tick(4'h5, 8, 8);
        chk("unhold_cnt", 32'(sample_cnt), 32'd5);
        check_digit(0, 7'b0010010, 1'b0);
        check_digit(1, 7'b1000000, 1'b1);

        // Capture landing on the refresh terminal count
        aligned = 1'b0;
        for (int i = 0; i < 16 && !aligned; i++) begin
            @(negedge clk_in);
            if (m_edge % DIV == 1) aligned = 1'b1;
        end
        chk("collision_align", 32'(aligned), 32'd1);
        tick(4'h7, 8, 8);
        chk("collision_cnt", 32'(sample_cnt), 32'd6);
        check_digit(0, 7'b1111000, 1'b0);

        // Random ticks, holds and level widths against the model
        for (int i = 0; i < 40; i++) begin
            hold = ($urandom_range(0, 3) == 0);
            tick(4'($urandom_range(0, 15)), 8 + $urandom_range(0, 12), 8 + $urandom_range(0, 12));
        end
        hold = 1'b0;

        // 256 accepted captures bring the counter back to where it was
        c0 = sample_cnt;
        for (int i = 0; i < 256; i++) tick(4'($urandom_range(0, 15)), 8, 8);
        chk("wrap_cnt", 32'(sample_cnt), 32'(c0));

        // Tick already high across reset release is not a capture
        reset    = 1'b1;
        state_in = 4'h3;
        tick_in  = 1'b1;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (12) @(negedge clk_in);
        chk("sync_hi_cnt", 32'(sample_cnt), 32'd0);
        check_digit(0, 7'h7F, 1'b1);
        tick_in = 1'b0;
        repeat (8) @(negedge clk_in);
        tick(4'h3, 8, 8);
        chk("sync_rise_cnt", 32'(sample_cnt), 32'd1);
        check_digit(0, 7'b0110000, 1'b0);

        repeat (4) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
